frag_coord_decode: RTL
======================

// Module: frag_coord_decode
// PURPOSE
//  Inverse of the z-buffer address calculator: takes a linear fragment id (row-major pixel index)
//  and returns integer pixel coords plus fp16 normalized screen coords x/SCR_W, y/SCR_H.
//  Sits downstream of z-buffer/frame readback so resolved fragments can be re-shaded in fp16 space.
//  Multi-cycle iterative datapath; one fragment in flight; nd/us_rfd and rdy/ds_rfd handshakes.
// PARAMETERS
//  SCR_W  640  screen width in pixels (divisor for x)
//  SCR_H  480  screen height in pixels (divisor for y)
//  IDW    19   frag_id width; must satisfy 2^IDW >= SCR_W*SCR_H
//  CW     10   integer coordinate width
//  NSH    10   normalize-phase cycles = clog2(max(SCR_W,SCR_H))
// PORTS
//  clk      in   1    clock, rising edge
//  rst      in   1    reset, asynchronous, active-low
//  nd       in   1    new data: frag_id valid
//  us_rfd   out  1    ready for data (upstream); accept = nd && us_rfd
//  frag_id  in   IDW  linear pixel index = y*SCR_W + x
//  ds_rfd   in   1    downstream ready; transfer = rdy && ds_rfd
//  rdy      out  1    outputs valid
//  pix_x    out  CW   integer x = frag_id % SCR_W
//  pix_y    out  CW   integer y = frag_id / SCR_W
//  fp_x     out  16   IEEE fp16 of pix_x/SCR_W, truncated
//  fp_y     out  16   IEEE fp16 of pix_y/SCR_H, truncated
//  err      out  1    only when RANGE_CHECK_EN defined
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; us_rfd=0 during reset, 1 first cycle after release; rdy=0; all data outs 0.
//  - FSM: IDLE -> DIV (IDW cyc) -> NORM (NSH cyc) -> MANT (10 cyc) -> OUT -> IDLE on transfer.
//  - us_rfd = (state==IDLE). frag_id latched on the accept edge; nd ignored outside IDLE.
//  - DIV: restoring long division of frag_id by SCR_W, 1 quotient bit/cycle MSB first -> pix_y, remainder pix_x.
//  - NORM: x and y operands in parallel (n, D): r=n, e=0; each cycle, if r!=0 && r<D then r<<=1, e++.
//  - MANT: rem=r-D; 10 cycles: rem<<=1; bit = rem>=D; if bit, rem-=D; bits MSB first = mantissa.
//  - Packing: n==0 -> 16'h0000; else {1'b0, 5'(15-e), mant[9:0]}; no rounding; no subnormals for D<=2^14.
//  - Latency: rdy rises exactly IDW+NSH+11 cycles after accept edge (40 for defaults); fixed, data-independent.
//  - OUT: rdy=1; outputs held stable while ds_rfd=0. On transfer, rdy=0 and us_rfd=1 next cycle.
//  - Outputs keep last value after transfer until next result; min initiation interval = latency+1.
//  - Reset mid-operation: in-flight fragment discarded, no rdy pulse emitted.
// CONFIGURATION
//  RANGE_CHECK_EN defined: err port present; frag_id >= SCR_W*SCR_H is accepted, same latency,
//    result pix_x=0, pix_y=0, fp_x=fp_y=16'h3C00, err=1 with rdy (err=0 for in-range ids).
//  Not defined: no err port; out-of-range frag_id gives unspecified outputs (latency still fixed).
// TESTING
//  1. frag_id=0 -> after 40 cyc rdy=1, pix=(0,0), fp_x=16'h0000, fp_y=16'h0000.
//  2. frag_id=246080 -> pix=(320,384), fp_x=16'h3800, fp_y=16'h3A66.
//  3. frag_id=247362 -> pix=(322,386), fp_x=16'h3806, fp_y=16'h3A6E; then frag_id=1 -> fp_x=16'h1666, fp_y=0.
//  4. frag_id=307199 -> pix=(639,479), fp_x=16'h3BFC, fp_y=16'h3BFB.
//  5. ds_rfd=0 for 5 cyc after rdy -> outputs stable, us_rfd=0, nd ignored; ds_rfd=1 -> us_rfd=1 next cyc.
//  6. rst=0 at cycle 20 of a job -> rdy/outputs 0 immediately, no rdy pulse; with RANGE_CHECK_EN,
//     frag_id=307200 -> err=1, fp_x=fp_y=16'h3C00, pix=(0,0).

Source files
------------

// File: rtl/frag_coord_decode.sv
// frag_coord_decode: linear fragment id -> pixel (x,y) and truncated fp16 x/SCR_W, y/SCR_H.
// Optional RANGE_CHECK_EN adds err and forces a fixed result for ids beyond the screen.
module frag_coord_decode #(
  parameter int SCR_W = 640,
  parameter int SCR_H = 480,
  parameter int IDW   = 19,
  parameter int CW    = 10,
  parameter int NSH   = 10
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           nd,
  output logic           us_rfd,
  input  logic [IDW-1:0] frag_id,
  input  logic           ds_rfd,
  output logic           rdy,
  output logic [CW-1:0]  pix_x,
  output logic [CW-1:0]  pix_y,
  output logic [15:0]    fp_x,
  output logic [15:0]    fp_y
`ifdef RANGE_CHECK_EN
  ,output logic          err
`endif
);
  localparam int MW  = SCR_W > SCR_H ? SCR_W : SCR_H;
  localparam int RW  = $clog2(MW) + 2;
  localparam int DW  = $clog2(SCR_W);
  localparam int DW1 = DW + 1;
  localparam int KW  = $clog2(IDW + NSH + 12);
  typedef enum logic [2:0] {IDLE, DIV, NORM, MANT, OUT} state_t;
  state_t          state;
  logic [KW-1:0]   cnt;
  logic [IDW-1:0]  q;
  logic [DW-1:0]   dr;
  logic [CW-1:0]   px, py;
  logic [RW-1:0]   rx, ry;
  logic [4:0]      ex, ey;
  logic [8:0]      mx, my;
  logic [DW:0]     dsh;
  logic            dge;
  logic [DW-1:0]   drn;
  logic            nx, ny, bx, by, bad;
  logic [RW-1:0]   sx, sy;
  logic [9:0]      mxn, myn;
  logic [15:0]     fpx, fpy;
  // restoring division step: quotient bits shift into q as the dividend shifts out
  assign dsh = {dr, q[IDW-1]};
  assign dge = dsh >= DW1'(SCR_W);
  assign drn = DW'(dge ? dsh - DW1'(SCR_W) : dsh);
  assign nx  = (rx != '0) && (rx < RW'(SCR_W));
  assign ny  = (ry != '0) && (ry < RW'(SCR_H));
  assign sx  = rx << 1;
  assign sy  = ry << 1;
  assign bx  = sx >= RW'(SCR_W);
  assign by  = sy >= RW'(SCR_H);
  assign mxn = {mx, bx};
  assign myn = {my, by};
  assign fpx = (px == '0) ? 16'h0000 : {1'b0, 5'd15 - ex, mxn};
  assign fpy = (py == '0) ? 16'h0000 : {1'b0, 5'd15 - ey, myn};
`ifdef RANGE_CHECK_EN
  logic oor;
  assign bad = oor;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      oor <= 1'b0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && nd && us_rfd) oor <= 32'(frag_id) >= SCR_W * SCR_H;
      if (state == MANT && cnt == KW'(10)) err <= oor;
    end
`else
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      us_rfd <= 1'b0;
      rdy    <= 1'b0;
      pix_x  <= '0;
      pix_y  <= '0;
      fp_x   <= '0;
      fp_y   <= '0;
      cnt    <= '0;
      q      <= '0;
      dr     <= '0;
      px     <= '0;
      py     <= '0;
      rx     <= '0;
      ry     <= '0;
      ex     <= '0;
      ey     <= '0;
      mx     <= '0;
      my     <= '0;
    end else begin
      case (state)
        IDLE: begin
          us_rfd <= !(nd && us_rfd);
          if (nd && us_rfd) begin
            q     <= frag_id;
            dr    <= '0;
            cnt   <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          q   <= {q[IDW-2:0], dge};
          dr  <= drn;
          cnt <= (cnt == KW'(IDW - 1)) ? '0 : cnt + 1'b1;
          if (cnt == KW'(IDW - 1)) begin
            px    <= CW'(drn);
            py    <= CW'({q[IDW-2:0], dge});
            rx    <= RW'(CW'(drn));
            ry    <= RW'(CW'({q[IDW-2:0], dge}));
            ex    <= '0;
            ey    <= '0;
            state <= NORM;
          end
        end
        NORM: begin
          rx  <= nx ? sx : rx;
          ry  <= ny ? sy : ry;
          ex  <= ex + 5'(nx);
          ey  <= ey + 5'(ny);
          cnt <= (cnt == KW'(NSH - 1)) ? '0 : cnt + 1'b1;
          if (cnt == KW'(NSH - 1)) state <= MANT;
        end
        MANT: begin
          // first cycle drops the implicit leading one, then 10 mantissa bits
          rx  <= (cnt == '0) ? rx - RW'(SCR_W) : (bx ? sx - RW'(SCR_W) : sx);
          ry  <= (cnt == '0) ? ry - RW'(SCR_H) : (by ? sy - RW'(SCR_H) : sy);
          mx  <= (cnt == '0) ? mx : mxn[8:0];
          my  <= (cnt == '0) ? my : myn[8:0];
          cnt <= cnt + 1'b1;
          if (cnt == KW'(10)) begin
            pix_x <= bad ? '0 : px;
            pix_y <= bad ? '0 : py;
            fp_x  <= bad ? 16'h3C00 : fpx;
            fp_y  <= bad ? 16'h3C00 : fpy;
            rdy   <= 1'b1;
            cnt   <= '0;
            state <= OUT;
          end
        end
        OUT: if (ds_rfd) begin
          rdy    <= 1'b0;
          us_rfd <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
